// File: rtl/dct_coeff_huffman_encoder.sv
// Bit-serial MPEG-1 DCT coefficient VLC encoder (ISO/IEC 11172-2 dct_coefficients).
// One (run, level) or EOB symbol per handshake; codeword shifted out MSB-first.
module dct_coeff_huffman_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [5:0] sym_run,
  input  logic [8:0] sym_level,
  input  logic       sym_first,
  input  logic       sym_eob,
  output logic       data_valid,
  output logic       data,
  output logic       data_last,
  input  logic       data_ready
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [27:0] sreg;
  logic [4:0]  cnt;
  logic [27:0] code_word;
  logic [4:0]  code_len;
  logic [8:0]  level_abs;
  logic        sign;
  logic [20:0] vlc;
  logic        accept;

  // Table VLC without the sign bit, returned as {length, code}; length 0 = not in table.
  // Codes are right-aligned values; their leading zeros are implied by the length.
  function automatic logic [20:0] vlc_lookup(input logic [5:0] run, input logic [8:0] lvl);
    logic [20:0] r;
    logic [5:0]  l;
    l = lvl[5:0];
    r = '0;
    if (lvl[8:6] != 3'd0) r = '0;
    else if (run == 6'd0 && l >= 6'd16 && l <= 6'd31) r = {5'd14, 10'd0, 6'd47 - l};
    else if (run == 6'd0 && l >= 6'd33 && l <= 6'd40) r = {5'd15, 10'd0, 6'd56 - l};
    else if (run == 6'd1 && l >= 6'd8  && l <= 6'd14) r = {5'd15, 10'd0, 6'd39 - l};
    else if (run == 6'd1 && l >= 6'd15 && l <= 6'd18) r = {5'd16, 10'd0, 6'd34 - l};
    else begin
      case ({run, l})
        {6'd1, 6'd1}: r = {5'd3, 16'd3};   {6'd0, 6'd2}: r = {5'd4, 16'd4};   {6'd2, 6'd1}: r = {5'd4, 16'd5};
        {6'd0, 6'd3}: r = {5'd5, 16'd5};   {6'd3, 6'd1}: r = {5'd5, 16'd7};   {6'd4, 6'd1}: r = {5'd5, 16'd6};
        {6'd1, 6'd2}: r = {5'd6, 16'd6};   {6'd5, 6'd1}: r = {5'd6, 16'd7};   {6'd6, 6'd1}: r = {5'd6, 16'd5};
        {6'd7, 6'd1}: r = {5'd6, 16'd4};   {6'd0, 6'd4}: r = {5'd7, 16'd6};   {6'd2, 6'd2}: r = {5'd7, 16'd4};
        {6'd8, 6'd1}: r = {5'd7, 16'd7};   {6'd9, 6'd1}: r = {5'd7, 16'd5};
        {6'd0, 6'd5}: r = {5'd8, 16'd38};  {6'd0, 6'd6}: r = {5'd8, 16'd33};  {6'd1, 6'd3}: r = {5'd8, 16'd37};
        {6'd3, 6'd2}: r = {5'd8, 16'd36};  {6'd10, 6'd1}: r = {5'd8, 16'd39}; {6'd11, 6'd1}: r = {5'd8, 16'd35};
        {6'd12, 6'd1}: r = {5'd8, 16'd34}; {6'd13, 6'd1}: r = {5'd8, 16'd32};
        {6'd0, 6'd7}: r = {5'd10, 16'd10}; {6'd1, 6'd4}: r = {5'd10, 16'd12}; {6'd2, 6'd3}: r = {5'd10, 16'd11};
        {6'd4, 6'd2}: r = {5'd10, 16'd15}; {6'd5, 6'd2}: r = {5'd10, 16'd9};  {6'd14, 6'd1}: r = {5'd10, 16'd14};
        {6'd15, 6'd1}: r = {5'd10, 16'd13}; {6'd16, 6'd1}: r = {5'd10, 16'd8};
        {6'd0, 6'd8}: r = {5'd12, 16'd29};  {6'd0, 6'd9}: r = {5'd12, 16'd24};  {6'd0, 6'd10}: r = {5'd12, 16'd19};
        {6'd0, 6'd11}: r = {5'd12, 16'd16}; {6'd1, 6'd5}: r = {5'd12, 16'd27};  {6'd2, 6'd4}: r = {5'd12, 16'd20};
        {6'd3, 6'd3}: r = {5'd12, 16'd28};  {6'd4, 6'd3}: r = {5'd12, 16'd18};  {6'd6, 6'd2}: r = {5'd12, 16'd30};
        {6'd7, 6'd2}: r = {5'd12, 16'd21};  {6'd8, 6'd2}: r = {5'd12, 16'd17};  {6'd17, 6'd1}: r = {5'd12, 16'd31};
        {6'd18, 6'd1}: r = {5'd12, 16'd26}; {6'd19, 6'd1}: r = {5'd12, 16'd25}; {6'd20, 6'd1}: r = {5'd12, 16'd23};
        {6'd21, 6'd1}: r = {5'd12, 16'd22};
        {6'd0, 6'd12}: r = {5'd13, 16'd26}; {6'd0, 6'd13}: r = {5'd13, 16'd25}; {6'd0, 6'd14}: r = {5'd13, 16'd24};
        {6'd0, 6'd15}: r = {5'd13, 16'd23}; {6'd1, 6'd6}: r = {5'd13, 16'd22};  {6'd1, 6'd7}: r = {5'd13, 16'd21};
        {6'd2, 6'd5}: r = {5'd13, 16'd20};  {6'd3, 6'd4}: r = {5'd13, 16'd19};  {6'd5, 6'd3}: r = {5'd13, 16'd18};
        {6'd9, 6'd2}: r = {5'd13, 16'd17};  {6'd10, 6'd2}: r = {5'd13, 16'd16}; {6'd22, 6'd1}: r = {5'd13, 16'd31};
        {6'd23, 6'd1}: r = {5'd13, 16'd30}; {6'd24, 6'd1}: r = {5'd13, 16'd29}; {6'd25, 6'd1}: r = {5'd13, 16'd28};
        {6'd26, 6'd1}: r = {5'd13, 16'd27};
        {6'd0, 6'd32}: r = {5'd15, 16'd24};
        {6'd6, 6'd3}: r = {5'd16, 16'd20};  {6'd11, 6'd2}: r = {5'd16, 16'd26}; {6'd12, 6'd2}: r = {5'd16, 16'd25};
        {6'd13, 6'd2}: r = {5'd16, 16'd24}; {6'd14, 6'd2}: r = {5'd16, 16'd23}; {6'd15, 6'd2}: r = {5'd16, 16'd22};
        {6'd16, 6'd2}: r = {5'd16, 16'd21}; {6'd27, 6'd1}: r = {5'd16, 16'd31}; {6'd28, 6'd1}: r = {5'd16, 16'd30};
        {6'd29, 6'd1}: r = {5'd16, 16'd29}; {6'd30, 6'd1}: r = {5'd16, 16'd28}; {6'd31, 6'd1}: r = {5'd16, 16'd27};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign accept    = sym_valid & sym_ready;
  assign data      = sreg[27];
  assign sym_ready = ~reset & ((state == IDLE) | (data_last & data_ready));

  // Form the left-aligned codeword and its length from the offered symbol.
  always_comb begin
    sign      = sym_level[8];
    level_abs = sym_level[8] ? (~sym_level + 9'd1) : sym_level;
    vlc       = vlc_lookup(sym_run, level_abs);
    code_word = '0;
    code_len  = '0;
    if (sym_eob) begin
      code_word = {2'b10, 26'd0};
      code_len  = 5'd2;
    end else if (sym_run == 6'd0 && level_abs == 9'd1) begin
      if (sym_first) begin
        code_word = {1'b1, sign, 26'd0};
        code_len  = 5'd2;
      end else begin
        code_word = {2'b11, sign, 25'd0};
        code_len  = 5'd3;
      end
    end else if (vlc[20:16] != 5'd0) begin
      code_word = {11'd0, vlc[15:0], sign} << (5'd27 - vlc[20:16]);
      code_len  = vlc[20:16] + 5'd1;
    end else if (level_abs[8:7] != 2'b00) begin
      // |level| >= 128 (and -256): marker byte 0x00/0x80 then the low level byte.
      code_word = {6'b000001, sym_run, sign, 7'd0, sym_level[7:0]};
      code_len  = 5'd28;
    end else begin
      code_word = {6'b000001, sym_run, sym_level[7:0], 8'd0};
      code_len  = 5'd20;
    end
  end

  // Control FSM and output shift register; a final-bit transfer may reload directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      sreg       <= code_word;
      cnt        <= code_len;
      data_valid <= 1'b1;
      data_last  <= (code_len == 5'd1);
    end else if (state == SHIFT && data_ready) begin
      sreg      <= sreg << 1;
      cnt       <= cnt - 5'd1;
      data_last <= (cnt == 5'd2);
      if (cnt == 5'd1) begin
        state      <= IDLE;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_coeff_huffman_encoder.sv
// Directed and randomized bench for dct_coeff_huffman_encoder.
module tb_dct_coeff_huffman_encoder;

  logic       clk, reset;
  logic       sym_valid, sym_ready;
  logic [5:0] sym_run;
  logic [8:0] sym_level;
  logic       sym_first, sym_eob;
  logic       data_valid, data, data_last, data_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // Pending symbols and expected bit stream
  int    q_run[$];
  int    q_lvl[$];
  bit    q_first[$];
  bit    q_eob[$];
  string q_exp[$];
  bit    eb[$];
  bit    el[$];

  // Subset of the dct_coefficients table used for random symbols (code without sign)
  int    tab_run [19] = '{1, 0, 2, 0, 4, 7, 9, 13, 2, 0, 21, 26, 0, 0, 1, 31, 6, 1, 0};
  int    tab_lvl [19] = '{1, 2, 1, 3, 1, 1, 1, 1, 3, 8, 1, 1, 20, 40, 14, 1, 3, 18, 5};
  string tab_vlc [19] = '{"011", "0100", "0101", "00101", "00110", "000100", "0000101",
                          "00100000", "0000001011", "000000011101", "000000010110",
                          "0000000011011", "00000000011011", "000000000010000",
                          "000000000011001", "0000000000011011", "0000000000010100",
                          "0000000000010000", "00100110"};

  int kind, idx, r_run, r_lvl;
  bit r_first, r_eob;
  string e;

  dct_coeff_huffman_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_run    (sym_run),
    .sym_level  (sym_level),
    .sym_first  (sym_first),
    .sym_eob    (sym_eob),
    .data_valid (data_valid),
    .data       (data),
    .data_last  (data_last),
    .data_ready (data_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string bits(input int v, input int n);
    string s;
    s = "";
    for (int i = n - 1; i >= 0; i--) begin
      if (((v >> i) & 1) != 0) s = {s, "1"};
      else s = {s, "0"};
    end
    return s;
  endfunction

  // Reference encoder for the symbol domain the random phase generates
  function automatic string enc(input int run, input int lvl, input bit first, input bit eob);
    int    a;
    string sg, s;
    a  = (lvl < 0) ? -lvl : lvl;
    sg = (lvl < 0) ? "1" : "0";
    if (eob) return "10";
    if (run == 0 && a == 1) return first ? {"1", sg} : {"11", sg};
    for (int i = 0; i < 19; i++)
      if (tab_run[i] == run && tab_lvl[i] == a) return {tab_vlc[i], sg};
    s = {"000001", bits(run, 6)};
    if (a >= 128) s = {s, (lvl < 0) ? "10000000" : "00000000"};
    return {s, bits(lvl & 255, 8)};
  endfunction

  task automatic push_sym(input int run, input int lvl, input bit first, input bit eob, input string exp);
    q_run.push_back(run);
    q_lvl.push_back(lvl);
    q_first.push_back(first);
    q_eob.push_back(eob);
    q_exp.push_back(exp);
  endtask

  // Offer queued symbols and consume bits until both queues drain or the budget expires
  task automatic run_stream(input string tag, input int ready_pct, input int budget);
    int    cyc;
    bit    have_hold, hold_d, hold_l;
    string s;
    cyc = 0;
    have_hold = 1'b0;
    hold_d = 1'b0;
    hold_l = 1'b0;
    while ((q_run.size() != 0 || eb.size() != 0 || data_valid) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (have_hold) begin
        check({tag, "_stall_valid"}, data_valid, 1);
        check({tag, "_stall_data"}, data, hold_d);
        check({tag, "_stall_last"}, data_last, hold_l);
      end
      data_ready = ($urandom_range(99) < ready_pct);
      if (q_run.size() != 0 && $urandom_range(3) != 0) begin
        sym_valid = 1'b1;
        sym_run   = 6'(q_run[0]);
        sym_level = 9'(q_lvl[0]);
        sym_first = q_first[0];
        sym_eob   = q_eob[0];
      end else begin
        sym_valid = 1'b0;
        sym_run   = 6'($urandom_range(63));
        sym_level = 9'($urandom_range(511));
        sym_first = 1'($urandom_range(1));
        sym_eob   = 1'($urandom_range(1));
      end
      #1;
      if (data_valid && data_ready) begin
        if (eb.size() == 0) check({tag, "_stray_valid"}, data_valid, 0);
        else begin
          check({tag, "_bit"}, data, eb.pop_front());
          check({tag, "_last"}, data_last, el.pop_front());
        end
      end
      have_hold = data_valid && !data_ready;
      hold_d = data;
      hold_l = data_last;
      if (sym_valid && sym_ready) begin
        s = q_exp.pop_front();
        void'(q_run.pop_front());
        void'(q_lvl.pop_front());
        void'(q_first.pop_front());
        void'(q_eob.pop_front());
        for (int i = 0; i < s.len(); i++) begin
          eb.push_back(s.getc(i) == 8'h31);
          el.push_back(i == s.len() - 1);
        end
      end
    end
    sym_valid = 1'b0;
    check({tag, "_drained"}, eb.size() + q_run.size(), 0);
  endtask

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym_run = '0; sym_level = '0;
    sym_first = 1'b0; sym_eob = 1'b0; data_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", data_valid, 0);
    check("rst_data", data, 0);
    check("rst_last", data_last, 0);
    check("rst_sym_ready", sym_ready, 0);
    reset = 1'b0;
    #1 check("rel_sym_ready", sym_ready, 1);

    // Short (0,+-1) codes with sym_first
    push_sym(0, 1, 1, 0, "10");
    push_sym(0, -1, 1, 0, "11");
    run_stream("first", 100, 200);

    // Back-to-back (0,+1) then EOB with no bubble
    @(negedge clk);
    data_ready = 1'b1; sym_valid = 1'b1; sym_run = 6'd0; sym_level = 9'd1;
    sym_first = 1'b0; sym_eob = 1'b0;
    #1 check("b2b_ready_idle", sym_ready, 1);
    e = "11010";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_valid", data_valid, 1);
      check("b2b_data", data, (e.getc(i) == 8'h31));
      check("b2b_last", data_last, (i == 2 || i == 4));
      check("b2b_sym_ready", sym_ready, (i == 2 || i == 4));
      if (i == 0) begin sym_eob = 1'b1; sym_run = 6'd9; sym_level = 9'h1f0; end
      if (i == 3) sym_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_valid", data_valid, 0);
    check("b2b_idle_ready", sym_ready, 1);

    // Table entries, escapes and boundary levels
    push_sym(1, 1, 0, 0, "0110");
    push_sym(0, -3, 0, 0, "001011");
    push_sym(31, 1, 0, 0, "00000000000110110");
    push_sym(0, -40, 0, 0, "0000000000100001");
    push_sym(1, 18, 0, 0, "00000000000100000");
    push_sym(0, 0, 1, 1, "10");
    push_sym(5, 10, 0, 0, "00000100010100001010");
    push_sym(0, 200, 0, 0, "0000010000000000000011001000");
    push_sym(0, -200, 0, 0, "0000010000001000000000111000");
    push_sym(0, -128, 0, 0, "0000010000001000000010000000");
    push_sym(0, 127, 0, 0, "00000100000001111111");
    push_sym(0, 0, 0, 0, "00000100000000000000");
    push_sym(0, -256, 0, 0, "0000010000001000000000000000");
    run_stream("directed", 100, 1000);

    // Random symbols against the reference encoder with random backpressure
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(3);
      r_first = 1'($urandom_range(1));
      r_eob = 1'b0;
      if (kind == 0) begin
        r_eob = 1'b1; r_run = $urandom_range(63); r_lvl = $urandom_range(255);
      end else if (kind == 1) begin
        r_run = 0; r_lvl = ($urandom_range(1) != 0) ? 1 : -1;
      end else if (kind == 2) begin
        idx = $urandom_range(18);
        r_run = tab_run[idx];
        r_lvl = ($urandom_range(1) != 0) ? -tab_lvl[idx] : tab_lvl[idx];
      end else if ($urandom_range(1) != 0) begin
        r_run = $urandom_range(63, 32); r_lvl = int'($urandom_range(510)) - 255;
      end else begin
        r_run = $urandom_range(31); r_lvl = $urandom_range(255, 41);
        if ($urandom_range(1) != 0) r_lvl = -r_lvl;
      end
      push_sym(r_run, r_lvl, r_first, r_eob, enc(r_run, r_lvl, r_first, r_eob));
    end
    run_stream("rand", 70, 60000);

    // Asynchronous reset at bit 7 of a 20-bit escape
    @(negedge clk);
    data_ready = 1'b1; sym_valid = 1'b1; sym_run = 6'd5; sym_level = 9'd10;
    sym_first = 1'b0; sym_eob = 1'b0;
    e = "00000100010100001010";
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      check("pre_rst_valid", data_valid, 1);
      check("pre_rst_bit", data, (e.getc(k - 1) == 8'h31));
    end
    #2 reset = 1'b1;
    #1;
    check("arst_valid", data_valid, 0);
    check("arst_data", data, 0);
    check("arst_last", data_last, 0);
    check("arst_sym_ready", sym_ready, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", data_valid, 0);
    check("post_rst_ready", sym_ready, 1);
    push_sym(1, 1, 0, 0, "0110");
    run_stream("after_rst", 100, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
